box_overlay_compositor: RTL and testbench

Pipelined, parametrised pixel compositor that sits between the sprite ROM path and the VGA driver. It draws up to NUM_BOXES rectangular hit/hurt-box outlines with per-box colour, blink and enable over the sprite pixel, then falls back to the background colour. Box geometry is shadow-latched once per frame, so game logic can update boxes mid-frame without tearing.

---
 rtl/overlay_pkg.sv | 36 +++
 rtl/box_border_hit.sv | 37 +++
 rtl/box_overlay_compositor.sv | 135 +++++++++++++
 tb/tb_box_overlay_compositor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared constants and box-state encodings for the box overlay compositor and
// the game logic that drives its box_en / box_color inputs.
package overlay_pkg;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_COLOR_W = 8;

    localparam logic [7:0] TRANSPARENT_COLOR = 8'hE3;
    localparam logic [7:0] BACKGROUND_COLOR  = 8'h7B;
    localparam logic [7:0] RED               = 8'hE0;
    localparam logic [7:0] YELLOW            = 8'hFC;

    // Active boxes (hitboxes) are drawn red, passive ones (hurtboxes) yellow.
    typedef enum logic [1:0] {
        BOX_OFF     = 2'd0,
        BOX_ACTIVE  = 2'd1,
        BOX_PASSIVE = 2'd2
    } box_state_e;

    function automatic logic box_state_en(input box_state_e state);
        case (state)
            BOX_ACTIVE:  return 1'b1;
            BOX_PASSIVE: return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] box_state_color(input box_state_e state);
        case (state)
            BOX_ACTIVE:  return RED;
            BOX_PASSIVE: return YELLOW;
            default:     return BACKGROUND_COLOR;
        endcase
    endfunction

endpackage

// File: rtl/box_border_hit.sv
// Combinational border test of one pixel against one inclusive rectangle.
// Degenerate boxes (x1 > x2 or y1 > y2) never report a hit.
module box_border_hit #(
    parameter int COORD_W = 10,
    parameter int THICK   = 1
) (
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] y2,
    output logic               hit
);

    localparam logic [COORD_W:0] THICK_W = (COORD_W+1)'(THICK);

    logic [COORD_W:0] px_s, py_s, x1_s, x2_s, y1_s, y2_s;
    logic             ordered_s, inside_s, near_edge_s;

    assign px_s = {1'b0, pix_x};
    assign py_s = {1'b0, pix_y};
    assign x1_s = {1'b0, x1};
    assign x2_s = {1'b0, x2};
    assign y1_s = {1'b0, y1};
    assign y2_s = {1'b0, y2};

    assign ordered_s = (x1_s <= x2_s) && (y1_s <= y2_s);
    assign inside_s  = (px_s >= x1_s) && (px_s <= x2_s) && (py_s >= y1_s) && (py_s <= y2_s);

    // Differences are non-negative whenever inside_s holds, so a narrow box is solid.
    assign near_edge_s = ((px_s - x1_s) < THICK_W) || ((x2_s - px_s) < THICK_W) ||
                         ((py_s - y1_s) < THICK_W) || ((y2_s - py_s) < THICK_W);

    assign hit = ordered_s && inside_s && near_edge_s;

endmodule

// File: rtl/box_overlay_compositor.sv
// Two-stage pixel compositor: box outlines over sprite over background, with
// box geometry shadow-latched on frame_start and a per-frame blink counter.
module box_overlay_compositor #(
    parameter int                   NUM_BOXES         = 6,
    parameter int                   COORD_W           = overlay_pkg::DEF_COORD_W,
    parameter int                   COLOR_W           = overlay_pkg::DEF_COLOR_W,
    parameter logic [COLOR_W-1:0]   TRANSPARENT_COLOR = overlay_pkg::TRANSPARENT_COLOR,
    parameter logic [COLOR_W-1:0]   BACKGROUND_COLOR  = overlay_pkg::BACKGROUND_COLOR,
    parameter int                   BLINK_FRAMES      = 8,
    parameter int                   THICK             = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_x1,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_x2,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_y1,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_y2,
    input  logic [NUM_BOXES-1:0]           box_en,
    input  logic [NUM_BOXES-1:0]           box_blink,
    input  logic [NUM_BOXES*COLOR_W-1:0]   box_color,
    input  logic                           pix_valid,
    input  logic [COORD_W-1:0]             pix_x,
    input  logic [COORD_W-1:0]             pix_y,
    input  logic [COLOR_W-1:0]             pixel_data,
    output logic                           out_valid,
    output logic [COLOR_W-1:0]             out_color
);

    import overlay_pkg::*;

    localparam int                FCNT_W    = $clog2(2*BLINK_FRAMES);
    localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(2*BLINK_FRAMES-1);
    localparam logic [FCNT_W-1:0] BLINK_LIM = FCNT_W'(BLINK_FRAMES);

    logic [NUM_BOXES*COORD_W-1:0] sh_x1_r, sh_x2_r, sh_y1_r, sh_y2_r;
    logic [NUM_BOXES-1:0]         sh_en_r, sh_blink_r;
    logic [NUM_BOXES*COLOR_W-1:0] sh_color_r;
    logic [FCNT_W-1:0]            fcnt_r;
    logic                         blink_off_s;
    logic [NUM_BOXES-1:0]         hit_raw_s, draw_s;

    logic [NUM_BOXES-1:0]         hit_r;
    logic [NUM_BOXES*COLOR_W-1:0] col_r;
    logic [COLOR_W-1:0]           pix_r;
    logic                         valid_r;
    logic [COLOR_W-1:0]           sel_color_s;

    // Shadow copy of the live box inputs, refreshed only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x1_r    <= '0;
            sh_x2_r    <= '0;
            sh_y1_r    <= '0;
            sh_y2_r    <= '0;
            sh_en_r    <= '0;
            sh_blink_r <= '0;
            sh_color_r <= '0;
        end else if (frame_start) begin
            sh_x1_r    <= box_x1;
            sh_x2_r    <= box_x2;
            sh_y1_r    <= box_y1;
            sh_y2_r    <= box_y2;
            sh_en_r    <= box_en;
            sh_blink_r <= box_blink;
            sh_color_r <= box_color;
        end
    end

    // Blink frame counter, 0 .. 2*BLINK_FRAMES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r <= '0;
        end else if (frame_start) begin
            fcnt_r <= (fcnt_r == FCNT_MAX) ? '0 : fcnt_r + 1'b1;
        end
    end

    assign blink_off_s = (fcnt_r >= BLINK_LIM);
    assign draw_s      = sh_en_r & ~(sh_blink_r & {NUM_BOXES{blink_off_s}});

    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
        box_border_hit #(
            .COORD_W (COORD_W),
            .THICK   (THICK)
        ) u_hit (
            .pix_x (pix_x),
            .pix_y (pix_y),
            .x1    (sh_x1_r[i*COORD_W +: COORD_W]),
            .x2    (sh_x2_r[i*COORD_W +: COORD_W]),
            .y1    (sh_y1_r[i*COORD_W +: COORD_W]),
            .y2    (sh_y2_r[i*COORD_W +: COORD_W]),
            .hit   (hit_raw_s[i])
        );
    end

    // Stage 1: hit vector plus the pixel, and the colours that matched its geometry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            hit_r   <= '0;
            pix_r   <= BACKGROUND_COLOR;
            col_r   <= '0;
        end else begin
            valid_r <= pix_valid;
            hit_r   <= hit_raw_s & draw_s;
            pix_r   <= pixel_data;
            col_r   <= sh_color_r;
        end
    end

    // Priority select: walking down to index 0 lets the lowest index win.
    always_comb begin
        if (pix_r != TRANSPARENT_COLOR) begin
            sel_color_s = pix_r;
        end else begin
            sel_color_s = BACKGROUND_COLOR;
        end
        for (int i = NUM_BOXES-1; i >= 0; i--) begin
            sel_color_s = hit_r[i] ? col_r[i*COLOR_W +: COLOR_W] : sel_color_s;
        end
    end

    // Stage 2: registered output, background forced on invalid pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_color <= BACKGROUND_COLOR;
        end else begin
            out_valid <= valid_r;
            out_color <= valid_r ? sel_color_s : BACKGROUND_COLOR;
        end
    end

endmodule

// File: tb/tb_box_overlay_compositor.sv
// Directed bench: a default instance and a THICK=2 / BLINK_FRAMES=2 instance
// share one stimulus stream; each step is checked with hand-computed colours.
module tb_box_overlay_compositor;

    localparam int N  = 6;
    localparam int CW = 10;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [N*CW-1:0] box_x1, box_x2, box_y1, box_y2;
    logic [N-1:0]    box_en, box_blink;
    logic [N*KW-1:0] box_color;
    logic            pix_valid;
    logic [CW-1:0]   pix_x, pix_y;
    logic [KW-1:0]   pixel_data;
    logic            out_valid, out_valid_t;
    logic [KW-1:0]   out_color, out_color_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    box_overlay_compositor dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .box_x1(box_x1), .box_x2(box_x2), .box_y1(box_y1), .box_y2(box_y2),
        .box_en(box_en), .box_blink(box_blink), .box_color(box_color),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pixel_data(pixel_data),
        .out_valid(out_valid), .out_color(out_color)
    );

    box_overlay_compositor #(.THICK(2), .BLINK_FRAMES(2)) dut_t (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .box_x1(box_x1), .box_x2(box_x2), .box_y1(box_y1), .box_y2(box_y2),
        .box_en(box_en), .box_blink(box_blink), .box_color(box_color),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pixel_data(pixel_data),
        .out_valid(out_valid_t), .out_color(out_color_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_box(input int i, input int x1, input int y1, input int x2, input int y2,
                           input logic en, input logic blink, input logic [7:0] color);
        box_x1[i*CW +: CW]    = CW'(x1);
        box_y1[i*CW +: CW]    = CW'(y1);
        box_x2[i*CW +: CW]    = CW'(x2);
        box_y2[i*CW +: CW]    = CW'(y2);
        box_en[i]             = en;
        box_blink[i]          = blink;
        box_color[i*KW +: KW] = color;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Present one pixel and wait the two-cycle pipeline latency.
    task automatic px(input int x, input int y, input logic [7:0] d);
        pix_valid  = 1'b1;
        pix_x      = CW'(x);
        pix_y      = CW'(y);
        pixel_data = d;
        step();
        pix_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; pixel_data = 8'h00;
        box_x1 = '0; box_x2 = '0; box_y1 = '0; box_y2 = '0;
        box_en = '0; box_blink = '0; box_color = '0;
        step(); step();
        chk("reset_valid", {7'd0, out_valid}, 8'h00);
        chk("reset_color", out_color, 8'h7B);
        chk("reset_color_t", out_color_t, 8'h7B);
        rst = 1'b0;

        // Live box without frame_start: shadow still empty, sprite shows through.
        set_box(0, 10, 10, 20, 20, 1'b1, 1'b0, 8'hE0);
        pix_valid = 1'b1; pix_x = 10'd10; pix_y = 10'd15; pixel_data = 8'h1F;
        step();
        pix_valid = 1'b0;
        chk("latency_not_yet", {7'd0, out_valid}, 8'h00);
        step();
        chk("no_fs_valid", {7'd0, out_valid}, 8'h01);
        chk("no_fs_color", out_color, 8'h1F);

        // Two overlapping boxes, index 0 wins.
        set_box(0, 10, 10, 20, 20, 1'b1, 1'b0, 8'hFC);
        set_box(1, 15, 10, 30, 20, 1'b1, 1'b0, 8'hE0);
        frame();
        px(15, 10, 8'h1F); chk("overlap_prio", out_color, 8'hFC);
        chk("overlap_valid", {7'd0, out_valid}, 8'h01);
        px(30, 12, 8'h1F); chk("box1_right", out_color, 8'hE0);
        px(12, 12, 8'hE3); chk("transparent_bg", out_color, 8'h7B);
        px(12, 12, 8'h55); chk("sprite_inner", out_color, 8'h55);
        px(20, 20, 8'h1F); chk("corner_x2y2", out_color, 8'hFC);
        pix_x = 10'd15; pix_y = 10'd10; pixel_data = 8'h1F;
        step(); step();
        chk("invalid_valid", {7'd0, out_valid}, 8'h00);
        chk("invalid_color", out_color, 8'h7B);

        // Border thickness: only dut_t has THICK=2.
        set_box(0, 0, 0, 9, 9, 1'b1, 1'b0, 8'hE0);
        set_box(1, 0, 0, 0, 0, 1'b0, 1'b0, 8'h00);
        frame();
        px(1, 5, 8'h1F);
        chk("thick2_hit", out_color_t, 8'hE0);
        chk("thick1_miss", out_color, 8'h1F);
        px(2, 5, 8'h1F); chk("thick2_inner", out_color_t, 8'h1F);
        px(9, 9, 8'h1F); chk("thick1_corner", out_color, 8'hE0);
        set_box(0, 0, 0, 2, 2, 1'b1, 1'b0, 8'hE0);
        frame();
        px(1, 1, 8'h1F); chk("thick2_solid", out_color_t, 8'hE0);

        // Mid-frame live change is ignored until the next frame_start.
        set_box(0, 10, 10, 20, 20, 1'b1, 1'b0, 8'hE0);
        frame();
        px(12, 10, 8'h1F); chk("midframe_before", out_color, 8'hE0);
        set_box(0, 30, 30, 40, 40, 1'b1, 1'b0, 8'hE0);
        px(12, 10, 8'h1F); chk("midframe_after", out_color, 8'hE0);
        pix_valid = 1'b1; pix_x = 10'd12; pix_y = 10'd10; pixel_data = 8'h1F;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; pix_valid = 1'b0;
        step();
        chk("fs_same_cycle_old", out_color, 8'hE0);
        px(12, 10, 8'h1F); chk("fs_new_geometry", out_color, 8'h1F);

        // Degenerate box (x1 > x2) is never drawn.
        set_box(0, 20, 10, 10, 20, 1'b1, 1'b0, 8'hE0);
        frame();
        px(15, 10, 8'h1F); chk("degenerate_top", out_color, 8'h1F);
        px(20, 15, 8'h1F); chk("degenerate_x1", out_color, 8'h1F);

        // Reset while streaming, together with frame_start (reset wins).
        set_box(0, 10, 10, 20, 20, 1'b1, 1'b1, 8'hE0);
        pix_valid = 1'b1; pix_x = 10'd12; pix_y = 10'd10; pixel_data = 8'h1F;
        step();
        rst = 1'b1; frame_start = 1'b1;
        step();
        chk("rst_flush_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_flush_color", out_color, 8'h7B);
        rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        px(12, 10, 8'h1F);
        chk("post_rst_hidden", out_color, 8'h1F);
        chk("post_rst_hidden_t", out_color_t, 8'h1F);
        chk("post_rst_valid", {7'd0, out_valid}, 8'h01);

        // Blink on dut_t (BLINK_FRAMES=2): fcnt 1 shown, 2-3 hidden, 0 shown.
        frame();
        px(12, 10, 8'h1F); chk("blink_f1_t", out_color_t, 8'hE0);
        chk("blink_f1", out_color, 8'hE0);
        frame();
        px(12, 10, 8'h1F); chk("blink_f2_t", out_color_t, 8'h1F);
        chk("blink_f2", out_color, 8'hE0);
        frame();
        px(12, 10, 8'h1F); chk("blink_f3_t", out_color_t, 8'h1F);
        frame();
        px(12, 10, 8'h1F); chk("blink_f4_t", out_color_t, 8'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
